// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with a main + skid buffer, valid/ready handshake,
// synchronous flush and a saturating backpressure-cycle counter.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int INST_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic              in_reg_we,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic              in_hi_we,
    input  logic              in_lo_we,
    input  logic [DATA_W-1:0] in_hi,
    input  logic [DATA_W-1:0] in_lo,
    input  logic [INST_W-1:0] in_inst,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_waddr,
    output logic              out_reg_we,
    output logic [DATA_W-1:0] out_alu_res,
    output logic              out_hi_we,
    output logic              out_lo_we,
    output logic [DATA_W-1:0] out_hi,
    output logic [DATA_W-1:0] out_lo,
    output logic [INST_W-1:0] out_inst,

    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic              reg_we;
        logic [DATA_W-1:0] alu_res;
        logic              hi_we;
        logic              lo_we;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic [INST_W-1:0] inst;
    } bundle_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    bundle_t          m_data_q,  m_data_d;
    bundle_t          s_data_q,  s_data_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    bundle_t in_data;
    logic    in_fire;
    logic    out_fire;
    logic    m_free;

    assign in_data = '{waddr: in_waddr, reg_we: in_reg_we, alu_res: in_alu_res,
                       hi_we: in_hi_we, lo_we: in_lo_we, hi: in_hi, lo: in_lo,
                       inst: in_inst};

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = m_valid_q & out_ready;
    assign m_free   = !m_valid_q || out_fire;

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        s_valid_d   = s_valid_q;
        s_data_d    = s_data_q;
        stall_cnt_d = stall_cnt_q;

        if (m_valid_q && !out_ready && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + 1'b1;

        if (rst) begin
            m_valid_d   = 1'b0;
            m_data_d    = '0;
            s_valid_d   = 1'b0;
            s_data_d    = '0;
            stall_cnt_d = '0;
        end else if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            s_valid_d = 1'b0;
            s_data_d  = '0;
        end else if (m_free) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
                s_data_d  = '0;
            end else if (in_fire) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
            end else begin
                // Empty M holds zeros so MEM sees a bubble with all enables off.
                m_valid_d = 1'b0;
                m_data_d  = '0;
            end
        end else if (in_fire) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
        end

        // Ready comes from a flop, so out_ready never reaches in_ready combinationally.
        in_ready_d = !s_valid_d;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        m_valid_q   <= m_valid_d;
        m_data_q    <= m_data_d;
        s_valid_q   <= s_valid_d;
        s_data_q    <= s_data_d;
        in_ready_q  <= in_ready_d;
        stall_cnt_q <= stall_cnt_d;
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = m_valid_q;
    assign out_waddr   = m_data_q.waddr;
    assign out_reg_we  = m_data_q.reg_we;
    assign out_alu_res = m_data_q.alu_res;
    assign out_hi_we   = m_data_q.hi_we;
    assign out_lo_we   = m_data_q.lo_we;
    assign out_hi      = m_data_q.hi;
    assign out_lo      = m_data_q.lo;
    assign out_inst    = m_data_q.inst;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed self-checking bench for ex_mem_skid (CNT_W=4 so saturation is reachable).
module tb_ex_mem_skid;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int INST_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic              in_valid, in_ready;
    logic [ADDR_W-1:0] in_waddr;
    logic              in_reg_we, in_hi_we, in_lo_we;
    logic [DATA_W-1:0] in_alu_res, in_hi, in_lo;
    logic [INST_W-1:0] in_inst;
    logic              out_valid, out_ready;
    logic [ADDR_W-1:0] out_waddr;
    logic              out_reg_we, out_hi_we, out_lo_we;
    logic [DATA_W-1:0] out_alu_res, out_hi, out_lo;
    logic [INST_W-1:0] out_inst;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ex_mem_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INST_W(INST_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_waddr(in_waddr),
        .in_reg_we(in_reg_we), .in_alu_res(in_alu_res), .in_hi_we(in_hi_we),
        .in_lo_we(in_lo_we), .in_hi(in_hi), .in_lo(in_lo), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_waddr(out_waddr),
        .out_reg_we(out_reg_we), .out_alu_res(out_alu_res), .out_hi_we(out_hi_we),
        .out_lo_we(out_lo_we), .out_hi(out_hi), .out_lo(out_lo), .out_inst(out_inst),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a bundle; hi/lo/inst are derived from alu so every field is traceable.
    task automatic offer(input logic v, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] alu);
        in_valid   = v;
        in_waddr   = wa;
        in_reg_we  = v;
        in_alu_res = alu;
        in_hi_we   = v;
        in_lo_we   = v;
        in_hi      = alu ^ 32'hFFFF_0000;
        in_lo      = alu ^ 32'h0000_FFFF;
        in_inst    = {alu[15:0], 16'h5A5A};
    endtask

    task automatic expect_bundle(input string tag, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] alu);
        check({tag, ".valid"},  out_valid, 1'b1);
        check({tag, ".waddr"},  out_waddr, wa);
        check({tag, ".reg_we"}, out_reg_we, 1'b1);
        check({tag, ".alu"},    out_alu_res, alu);
        check({tag, ".hi_we"},  out_hi_we, 1'b1);
        check({tag, ".lo_we"},  out_lo_we, 1'b1);
        check({tag, ".hi"},     out_hi, alu ^ 32'hFFFF_0000);
        check({tag, ".lo"},     out_lo, alu ^ 32'h0000_FFFF);
        check({tag, ".inst"},   out_inst, {alu[15:0], 16'h5A5A});
    endtask

    task automatic expect_bubble(input string tag);
        check({tag, ".valid"},  out_valid, 1'b0);
        check({tag, ".waddr"},  out_waddr, '0);
        check({tag, ".reg_we"}, out_reg_we, 1'b0);
        check({tag, ".alu"},    out_alu_res, '0);
        check({tag, ".hi_we"},  out_hi_we, 1'b0);
        check({tag, ".lo_we"},  out_lo_we, 1'b0);
        check({tag, ".hi"},     out_hi, '0);
        check({tag, ".lo"},     out_lo, '0);
        check({tag, ".inst"},   out_inst, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        offer(1'b0, '0, '0);

        // Reset with garbage offered
        rst = 1'b1;
        offer(1'b1, 5'd31, 32'hDEAD_BEEF);
        step();
        step();
        expect_bubble("rst_hold");
        check("rst_hold.in_ready", in_ready, 1'b1);
        check("rst_hold.stall", stall_cnt, 4'd0);
        rst = 1'b0;
        offer(1'b0, '0, '0);
        step();
        expect_bubble("rst_rel");
        check("rst_rel.in_ready", in_ready, 1'b1);
        check("rst_rel.stall", stall_cnt, 4'd0);

        // Streaming
        out_ready = 1'b1;
        offer(1'b1, 5'd1, 32'h11);
        step();
        expect_bundle("s1", 5'd1, 32'h11);
        check("s1.in_ready", in_ready, 1'b1);
        offer(1'b1, 5'd2, 32'h22);
        step();
        expect_bundle("s2", 5'd2, 32'h22);
        check("s2.in_ready", in_ready, 1'b1);
        offer(1'b1, 5'd3, 32'h33);
        step();
        expect_bundle("s3", 5'd3, 32'h33);
        check("s3.in_ready", in_ready, 1'b1);
        offer(1'b0, '0, '0);
        step();
        expect_bubble("s_end");
        check("s_end.stall", stall_cnt, 4'd0);

        // Backpressure
        out_ready = 1'b0;
        offer(1'b1, 5'd4, 32'hA);
        step();
        expect_bundle("bp_a", 5'd4, 32'hA);
        check("bp_a.in_ready", in_ready, 1'b1);
        check("bp_a.stall", stall_cnt, 4'd0);
        offer(1'b1, 5'd5, 32'hB);
        step();
        expect_bundle("bp_b_held", 5'd4, 32'hA);
        check("bp_b.in_ready", in_ready, 1'b0);
        check("bp_b.stall", stall_cnt, 4'd1);
        offer(1'b1, 5'd6, 32'hC);
        step();
        check("bp_c1.in_ready", in_ready, 1'b0);
        check("bp_c1.alu", out_alu_res, 32'hA);
        check("bp_c1.stall", stall_cnt, 4'd2);
        step();
        check("bp_c2.in_ready", in_ready, 1'b0);
        check("bp_c2.alu", out_alu_res, 32'hA);
        check("bp_c2.stall", stall_cnt, 4'd3);
        out_ready = 1'b1;
        step();
        expect_bundle("bp_out_b", 5'd5, 32'hB);
        check("bp_out_b.in_ready", in_ready, 1'b1);
        step();
        expect_bundle("bp_out_c", 5'd6, 32'hC);
        offer(1'b0, '0, '0);
        step();
        expect_bubble("bp_end");
        check("bp_end.stall", stall_cnt, 4'd3);

        // Flush with full buffer, D offered
        do_reset();
        out_ready = 1'b0;
        offer(1'b1, 5'd7, 32'hA0);
        step();
        offer(1'b1, 5'd8, 32'hB0);
        step();
        check("fl_full.in_ready", in_ready, 1'b0);
        flush = 1'b1;
        offer(1'b1, 5'd9, 32'hD0);
        step();
        flush = 1'b0;
        offer(1'b0, '0, '0);
        expect_bubble("fl_full");
        check("fl_full.in_ready_after", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        expect_bubble("fl_full_drain1");
        step();
        expect_bubble("fl_full_drain2");

        // Flush with M only: D is dropped although in_ready=1
        out_ready = 1'b0;
        offer(1'b1, 5'd10, 32'hA1);
        step();
        check("fl_m.in_ready", in_ready, 1'b1);
        flush = 1'b1;
        offer(1'b1, 5'd11, 32'hD1);
        step();
        flush = 1'b0;
        offer(1'b0, '0, '0);
        expect_bubble("fl_m");
        check("fl_m.in_ready_after", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        expect_bubble("fl_m_drain");

        // Flush and reset together
        do_reset();
        out_ready = 1'b0;
        offer(1'b1, 5'd12, 32'hE0);
        step();
        offer(1'b1, 5'd13, 32'hE1);
        step();
        step();
        check("pri_pre.stall", stall_cnt, 4'd2);
        flush = 1'b1;
        rst = 1'b1;
        step();
        flush = 1'b0;
        rst = 1'b0;
        offer(1'b0, '0, '0);
        expect_bubble("pri");
        check("pri.in_ready", in_ready, 1'b1);
        check("pri.stall", stall_cnt, 4'd0);

        // Counter saturation
        out_ready = 1'b0;
        offer(1'b1, 5'd17, 32'hCAFE_F00D);
        step();
        offer(1'b0, '0, '0);
        check("sat_load.stall", stall_cnt, 4'd0);
        for (int i = 1; i <= 20; i++) begin
            step();
            check("sat.alu", out_alu_res, 32'hCAFE_F00D);
            check("sat.valid", out_valid, 1'b1);
            check("sat.stall", stall_cnt, (i < 15) ? 64'(i) : 64'd15);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check("sat_hold.stall", stall_cnt, 4'd15);
        end
        expect_bundle("sat_end", 5'd17, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
